brush_painter: RTL and testbench
================================

// Module: brush_painter
// PURPOSE
//  Turns decoded SPI paint commands into a stream of single-pixel writes for the
//  pixel store's write port (wx/wy/newColor/we).
//  Sits between spiTop and pixelStore; runs in the 25.175 MHz VGA clock domain.
//  Each stroke command stamps a square brush footprint around (x,y).
//  A clear command sweeps the whole canvas to the background colour.
// PARAMETERS
//  GRID_W   160  canvas width in cells; x range 0..GRID_W-1
//  GRID_H   120  canvas height in cells; y range 0..GRID_H-1
//  BRUSH_R  1    brush radius; footprint is (2*BRUSH_R+1)^2 cells; 0 = single cell
//  BG_COLOR 3'b000  colour code written by erase and clear
// PORTS
//  clk        in   1   pixel clock
//  reset      in   1   synchronous, active-high
//  cmd_valid  in   1   command present this cycle
//  cmd_ready  out  1   command accepted when cmd_valid & cmd_ready
//  cmd_x      in   8   brush centre x
//  cmd_y      in   8   brush centre y
//  cmd_color  in   3   stroke colour code
//  cmd_erase  in   1   1 = paint BG_COLOR instead of cmd_color (brush off)
//  cmd_clear  in   1   1 = full-canvas clear; x/y/color ignored
//  wr_en      out  1   pixel write strobe, one cell per cycle
//  wr_x       out  10  write column, zero-extended
//  wr_y       out  10  write row, zero-extended
//  wr_color   out  3   write colour code
//  busy       out  1   engine not IDLE, or pending slot full
//  overflow   out  1   sticky: a command was offered while cmd_ready=0; cleared only by reset
// BEHAVIOUR
//  Reset values: wr_en=0, wr_x=0, wr_y=0, wr_color=0, busy=0, overflow=0.
//  Reset also empties the pending slot and puts FSM in IDLE. Reset mid-operation
//  aborts immediately; wr_en is 0 the cycle after reset is sampled.
//  Input buffer: one pending slot; cmd_ready = ~pend_valid | pop.
//  Accept and pop in the same cycle loads the new command into the slot.
//  The slot holds the command with erase already resolved to BG_COLOR.
//  FSM states IDLE, PAINT, CLEAR. All outputs are registered.
//  IDLE: if pend_valid, pop it. cmd_clear -> CLEAR, otherwise -> PAINT.
//  Latency: command accepted in cycle N -> in slot N+1 -> popped N+1 -> first wr_en at N+2.
//  PAINT: dy outer loop, dx inner loop, each from -BRUSH_R to +BRUSH_R.
//  One cell per cycle; exactly (2R+1)^2 cycles per stroke.
//  Cell = centre + offset in 11-bit signed arithmetic.
//  A cell with a negative coordinate, x>=GRID_W or y>=GRID_H keeps its cycle
//  with wr_en=0 (clipping, no wrap-around).
//  An out-of-range centre is legal; it just clips more cells.
//  CLEAR: row-major sweep (y outer, x inner) over all GRID_W*GRID_H cells with
//  BG_COLOR, wr_en=1 every cycle.
//  Leaving PAINT/CLEAR: after the cycle that issues the last cell -> IDLE.
//  That IDLE cycle may pop the next command (1 bubble between commands).
//  wr_x/wr_y/wr_color hold their last values while wr_en=0.
//  overflow sets on any cycle with cmd_valid & ~cmd_ready; that command is dropped.
// STRUCTURE
//  paint_pkg: state enum {IDLE,PAINT,CLEAR}; paint_cmd_t struct {x,y,color,clear};
//  BG_COLOR default constant; colour codes shared with colors.svh.
//  No sub-module. Pending slot, FSM and offset/sweep counters all live in
//  brush_painter.
// TESTING
//  1. R=1, cmd (50,40,color=2) -> 9 writes in order (49,39)..(51,41), all color 2;
//     first wr_en 2 cycles after accept.
//  2. R=1, cmd (0,0) -> 9 cycles, wr_en only for (0,0),(1,0),(0,1),(1,1).
//     Also cmd (159,119) -> only 4 in-range writes.
//  3. cmd_erase=1, color=5 -> all writes use BG_COLOR 0.
//     cmd_clear -> 19200 consecutive writes, last (159,119), then busy=0.
//  4. Three back-to-back cmds with cmd_valid held -> first two accepted, third
//     refused and overflow=1. One idle cycle between strokes; overflow stays 1 until reset.
//  5. Reset asserted mid-CLEAR at cell 1000 -> wr_en=0, busy=0, pending empty next cycle.
//     A fresh command then paints normally.

Source files
------------

// File: rtl/brush_painter_pkg.sv
// -----------------------------------------------------------------------------
// brush_painter_pkg
//   Shared types and defaults for the brush painter. It holds the FSM state
//   encoding, the pending-command record and the colour codes that the pixel
//   store and the VGA palette also use. It also provides a helper that folds
//   the erase flag into the stored colour.
// -----------------------------------------------------------------------------
package brush_painter_pkg;

    // Canvas and brush defaults.
    localparam int unsigned GRID_W_DEF  = 160;
    localparam int unsigned GRID_H_DEF  = 120;
    localparam int unsigned BRUSH_R_DEF = 1;

    // 3-bit colour codes used by the pixel store and the palette.
    typedef enum logic [2:0] {
        COLOR_BLACK   = 3'd0,
        COLOR_RED     = 3'd1,
        COLOR_GREEN   = 3'd2,
        COLOR_BLUE    = 3'd3,
        COLOR_YELLOW  = 3'd4,
        COLOR_CYAN    = 3'd5,
        COLOR_MAGENTA = 3'd6,
        COLOR_WHITE   = 3'd7
    } color_e;

    localparam logic [2:0] BG_COLOR_DEF = COLOR_BLACK;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAINT = 2'd1,
        CLEAR = 2'd2
    } state_e;

    // Pending command with erase already resolved into the colour field.
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] color;
        logic       clear;
    } paint_cmd_t;

    function automatic paint_cmd_t make_cmd(
        input logic [7:0] x,
        input logic [7:0] y,
        input logic [2:0] color,
        input logic       erase,
        input logic       clear,
        input logic [2:0] bg_color
    );
        paint_cmd_t c;
        c.x     = x;
        c.y     = y;
        c.color = erase ? bg_color : color;
        c.clear = clear;
        return c;
    endfunction

endpackage

// File: rtl/brush_painter_if.sv
// -----------------------------------------------------------------------------
// brush_painter_if
//   Bundles the two buses of the brush painter.
//   The command side is a valid/ready handshake that comes from the SPI
//   decoder. The pixel-write side drives the pixel store's write port.
//   master : command source / pixel sink (the SPI side and the pixel store).
//   slave  : the painter itself.
//   Signals:
//     cmd_valid, cmd_ready     command handshake
//     cmd_x, cmd_y             brush centre
//     cmd_color                stroke colour code
//     cmd_erase, cmd_clear     erase stroke / full-canvas clear
//     wr_en, wr_x, wr_y        pixel write strobe and coordinates
//     wr_color                 pixel colour code
// -----------------------------------------------------------------------------
interface brush_painter_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x;
    logic [7:0] cmd_y;
    logic [2:0] cmd_color;
    logic       cmd_erase;
    logic       cmd_clear;

    logic       wr_en;
    logic [9:0] wr_x;
    logic [9:0] wr_y;
    logic [2:0] wr_color;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_color, cmd_erase, cmd_clear,
        input  cmd_ready,
        input  wr_en, wr_x, wr_y, wr_color
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_color, cmd_erase, cmd_clear,
        output cmd_ready,
        output wr_en, wr_x, wr_y, wr_color
    );

endinterface

// File: rtl/brush_painter.sv
// -----------------------------------------------------------------------------
// brush_painter
//   Turns decoded paint commands into single-pixel writes, one cell per clock.
//   A stroke stamps a (2*BRUSH_R+1)^2 square around its centre and clips cells
//   that fall off the canvas. A clear command sweeps the whole canvas
//   row-major with BG_COLOR. A one-entry pending slot decouples the command
//   handshake from the engine.
//   Ports:
//     clk         pixel clock
//     reset       synchronous, active-high
//     bus         brush_painter_if.slave (command handshake + pixel writes)
//     busy_o      engine active or pending slot occupied
//     overflow_o  sticky: a command was offered while not ready
// -----------------------------------------------------------------------------
module brush_painter
    import brush_painter_pkg::*;
#(
    parameter int unsigned GRID_W   = GRID_W_DEF,
    parameter int unsigned GRID_H   = GRID_H_DEF,
    parameter int unsigned BRUSH_R  = BRUSH_R_DEF,
    parameter logic [2:0]  BG_COLOR = BG_COLOR_DEF
) (
    input  logic           clk,
    input  logic           reset,
    brush_painter_if.slave bus,
    output logic           busy_o,
    output logic           overflow_o
);

    localparam logic signed [10:0] R_S    = 11'(BRUSH_R);
    localparam logic [9:0]         LIM_X  = 10'(GRID_W);
    localparam logic [9:0]         LIM_Y  = 10'(GRID_H);
    localparam logic [9:0]         LAST_X = 10'(GRID_W - 1);
    localparam logic [9:0]         LAST_Y = 10'(GRID_H - 1);

    // Pending slot.
    paint_cmd_t pend_q, pend_d;
    logic       pend_valid_q, pend_valid_d;
    logic       pop, accept, cmd_ready;

    // Engine state. The stroke centre and colour are latched on pop.
    // dx/dy hold the offset of the cell that is currently on the outputs.
    state_e            state_q, state_d;
    logic [7:0]        cx_q, cx_d, cy_q, cy_d;
    logic [2:0]        col_q, col_d;
    logic signed [10:0] dx_q, dx_d, dy_q, dy_d;

    // Registered pixel-write outputs.
    logic       wr_en_q, wr_en_d;
    logic [9:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d;
    logic [2:0] wr_color_q, wr_color_d;
    logic       busy_q, overflow_q;

    // Cell under evaluation for a stroke.
    logic              issue;
    logic signed [10:0] cell_x, cell_y;
    logic              cell_ok;

    // The slot can take a new command when it is empty or is being drained
    // this very cycle.
    assign pop       = (state_q == IDLE) && pend_valid_q;
    assign cmd_ready = !pend_valid_q || pop;
    assign accept    = bus.cmd_valid && cmd_ready;

    // ------------------------------------------------------------------
    // Pending slot next state
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so the
        // block can never infer a latch on an unassigned path.
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (accept) begin
            pend_d       = make_cmd(bus.cmd_x, bus.cmd_y, bus.cmd_color,
                                    bus.cmd_erase, bus.cmd_clear, BG_COLOR);
            pend_valid_d = 1'b1;
        end else if (pop) begin
            pend_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and next outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        col_d      = col_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        wr_en_d    = 1'b0;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_color_d = wr_color_q;
        issue      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    if (pend_q.clear) begin
                        // The first sweep cell goes out on the same edge as
                        // the state change, which gives the two-cycle
                        // accept-to-write latency.
                        state_d    = CLEAR;
                        wr_en_d    = 1'b1;
                        wr_x_d     = '0;
                        wr_y_d     = '0;
                        wr_color_d = BG_COLOR;
                    end else begin
                        state_d = PAINT;
                        cx_d    = pend_q.x;
                        cy_d    = pend_q.y;
                        col_d   = pend_q.color;
                        dx_d    = -R_S;
                        dy_d    = -R_S;
                        issue   = 1'b1;
                    end
                end
            end

            PAINT: begin
                if (dx_q == R_S && dy_q == R_S) begin
                    state_d = IDLE;
                end else begin
                    if (dx_q == R_S) begin
                        dx_d = -R_S;
                        dy_d = dy_q + 11'sd1;
                    end else begin
                        dx_d = dx_q + 11'sd1;
                    end
                    issue = 1'b1;
                end
            end

            CLEAR: begin
                wr_color_d = BG_COLOR;
                if (wr_x_q == LAST_X) begin
                    if (wr_y_q == LAST_Y) begin
                        state_d = IDLE;
                    end else begin
                        wr_en_d = 1'b1;
                        wr_x_d  = '0;
                        wr_y_d  = wr_y_q + 10'd1;
                    end
                end else begin
                    wr_en_d = 1'b1;
                    wr_x_d  = wr_x_q + 10'd1;
                end
            end

            default: state_d = IDLE;
        endcase

        // A clipped cell still uses its cycle. It just does not strobe, and
        // the coordinates keep their previous value.
        cell_x  = $signed({3'b000, cx_d}) + dx_d;
        cell_y  = $signed({3'b000, cy_d}) + dy_d;
        cell_ok = !cell_x[10] && !cell_y[10] &&
                  (cell_x[9:0] < LIM_X) && (cell_y[9:0] < LIM_Y);
        if (issue && cell_ok) begin
            wr_en_d    = 1'b1;
            wr_x_d     = cell_x[9:0];
            wr_y_d     = cell_y[9:0];
            wr_color_d = col_d;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            col_q        <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            wr_en_q      <= 1'b0;
            wr_x_q       <= '0;
            wr_y_q       <= '0;
            wr_color_q   <= '0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            col_q        <= col_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            wr_en_q      <= wr_en_d;
            wr_x_q       <= wr_x_d;
            wr_y_q       <= wr_y_d;
            wr_color_q   <= wr_color_d;
            busy_q       <= (state_d != IDLE) || pend_valid_d;
            overflow_q   <= overflow_q || (bus.cmd_valid && !cmd_ready);
        end
    end

    // NOTE: the slot payload has no reset. It is only read while
    // pend_valid_q is set, and the load always writes that flag.
    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_x      = wr_x_q;
    assign bus.wr_y      = wr_y_q;
    assign bus.wr_color  = wr_color_q;
    assign busy_o        = busy_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_brush_painter.sv
// -----------------------------------------------------------------------------
// tb_brush_painter
//   Bench for brush_painter with the default 160x120 canvas, radius 1 and
//   background colour 0. Expected pixel writes come from a reference stamp
//   loop. They are queued when a command is driven and popped by a monitor
//   on every observed write.
// -----------------------------------------------------------------------------
module tb_brush_painter;

    localparam int GW = 160;
    localparam int GH = 120;
    localparam int BR = 1;

    typedef struct {
        int x;
        int y;
        int c;
    } exp_t;

    typedef struct {
        int x;
        int y;
        int color;
        bit erase;
        int exp_wr;
    } vec_t;

    logic clk;
    logic reset;
    logic busy;
    logic overflow;

    brush_painter_if bus ();

    brush_painter dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy_o     (busy),
        .overflow_o (overflow)
    );

    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   wr_count = 0;
    int   last_x   = -1;
    int   last_y   = -1;
    exp_t sb[$];
    int   wr_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every observed write must match the head of the queue.
    always @(negedge clk) begin
        cyc++;
        if (!reset && bus.wr_en === 1'b1) begin
            wr_count++;
            wr_cyc.push_back(cyc);
            last_x = int'(bus.wr_x);
            last_y = int'(bus.wr_y);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got write (%0d,%0d,c%0d) expected none",
                         bus.wr_x, bus.wr_y, bus.wr_color);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (int'(bus.wr_x) != e.x || int'(bus.wr_y) != e.y || int'(bus.wr_color) != e.c) begin
                    errors++;
                    $display("FAIL wr_px: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                             bus.wr_x, bus.wr_y, bus.wr_color, e.x, e.y, e.c);
                end
            end
        end
    end

    // Reference stamp: dy outer, dx inner, clipped to the canvas.
    task automatic push_stroke(input int x, input int y, input int color, input bit erase);
        for (int dy = -BR; dy <= BR; dy++) begin
            for (int dx = -BR; dx <= BR; dx++) begin
                exp_t e;
                e.x = x + dx;
                e.y = y + dy;
                e.c = erase ? 0 : color;
                if (e.x >= 0 && e.x < GW && e.y >= 0 && e.y < GH)
                    sb.push_back(e);
            end
        end
    endtask

    task automatic push_clear();
        for (int y = 0; y < GH; y++) begin
            for (int x = 0; x < GW; x++) begin
                exp_t e;
                e.x = x;
                e.y = y;
                e.c = 0;
                sb.push_back(e);
            end
        end
    endtask

    task automatic drive(input int x, input int y, input int color, input bit erase, input bit clr);
        bus.cmd_valid = 1'b1;
        bus.cmd_x     = 8'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_color = 3'(color);
        bus.cmd_erase = erase;
        bus.cmd_clear = clr;
    endtask

    // Offer one command for a single cycle; the slot is expected to be free.
    task automatic send(input int x, input int y, input int color, input bit erase, input bit clr);
        @(negedge clk);
        drive(x, y, color, erase, clr);
        check("send_ready", 32'(bus.cmd_ready), 32'd1);
        if (clr) push_clear();
        else     push_stroke(x, y, color, erase);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Wait for the engine to drain, counting busy cycles.
    task automatic wait_idle(output int busy_cycles);
        bit done;
        busy_cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 30000 && !done; i++) begin
            if (!busy && !bus.wr_en) done = 1'b1;
            else begin
                if (busy) busy_cycles++;
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy after 30000 cycles expected idle");
        end
    endtask

    vec_t vecs[9];

    initial begin
        int bc;
        int wr0;
        int base;

        vecs[0] = '{50, 40, 2, 1'b0, 9};
        vecs[1] = '{0, 0, 3, 1'b0, 4};
        vecs[2] = '{159, 119, 4, 1'b0, 4};
        vecs[3] = '{10, 10, 5, 1'b1, 9};
        vecs[4] = '{0, 60, 1, 1'b0, 6};
        vecs[5] = '{80, 0, 7, 1'b0, 6};
        vecs[6] = '{160, 60, 6, 1'b0, 3};
        vecs[7] = '{200, 200, 2, 1'b0, 0};
        vecs[8] = '{159, 0, 1, 1'b0, 4};

        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_color = '0;
        bus.cmd_erase = 1'b0;
        bus.cmd_clear = 1'b0;
        reset         = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_x", 32'(bus.wr_x), 32'd0);
        check("rst_wr_y", 32'(bus.wr_y), 32'd0);
        check("rst_wr_color", 32'(bus.wr_color), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        // Stroke latency: accept edge, slot cycle, then the first write.
        @(negedge clk);
        drive(50, 40, 2, 1'b0, 1'b0);
        check("lat_ready", 32'(bus.cmd_ready), 32'd1);
        push_stroke(50, 40, 2, 1'b0);
        wr0 = wr_count;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("lat_n1_wr_en", 32'(bus.wr_en), 32'd0);
        check("lat_n1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_n2_wr_en", 32'(bus.wr_en), 32'd1);
        check("lat_n2_wr_x", 32'(bus.wr_x), 32'd49);
        check("lat_n2_wr_y", 32'(bus.wr_y), 32'd39);
        wait_idle(bc);
        check("lat_count", 32'(wr_count - wr0), 32'd9);
        check("lat_last_x", 32'(last_x), 32'd51);
        check("lat_last_y", 32'(last_y), 32'd41);

        // Table of strokes: clipping, erase and out-of-range centres.
        for (int i = 0; i < 9; i++) begin
            wr0 = wr_count;
            send(vecs[i].x, vecs[i].y, vecs[i].color, vecs[i].erase, 1'b0);
            wait_idle(bc);
            check($sformatf("vec%0d_count", i), 32'(wr_count - wr0), 32'(vecs[i].exp_wr));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd10);
            check($sformatf("vec%0d_sb_empty", i), 32'(sb.size()), 32'd0);
        end

        // Full clear: 19200 consecutive writes ending at the far corner.
        wr0 = wr_count;
        wr_cyc.delete();
        send(0, 0, 0, 1'b0, 1'b1);
        wait_idle(bc);
        check("clr_count", 32'(wr_count - wr0), 32'd19200);
        check("clr_busy_cycles", 32'(bc), 32'd19201);
        check("clr_last_x", 32'(last_x), 32'd159);
        check("clr_last_y", 32'(last_y), 32'd119);
        check("clr_contiguous", 32'(wr_cyc[wr_cyc.size()-1] - wr_cyc[0]), 32'd19199);
        check("clr_busy_after", 32'(busy), 32'd0);

        // Back-to-back commands with valid held: third is refused.
        wr0 = wr_count;
        wr_cyc.delete();
        @(negedge clk);
        drive(20, 20, 1, 1'b0, 1'b0);
        check("b2b_a_ready", 32'(bus.cmd_ready), 32'd1);
        push_stroke(20, 20, 1, 1'b0);
        @(negedge clk);
        drive(22, 22, 6, 1'b0, 1'b0);
        check("b2b_b_ready", 32'(bus.cmd_ready), 32'd1);
        push_stroke(22, 22, 6, 1'b0);
        @(negedge clk);
        drive(100, 100, 7, 1'b0, 1'b0);
        check("b2b_c_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("b2b_overflow", 32'(overflow), 32'd1);
        wait_idle(bc);
        check("b2b_count", 32'(wr_count - wr0), 32'd18);
        if (wr_cyc.size() == 18) begin
            check("b2b_a_span", 32'(wr_cyc[8] - wr_cyc[0]), 32'd8);
            check("b2b_bubble", 32'(wr_cyc[9] - wr_cyc[8]), 32'd2);
            check("b2b_b_span", 32'(wr_cyc[17] - wr_cyc[9]), 32'd8);
        end
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);
        send(70, 70, 3, 1'b0, 1'b0);
        wait_idle(bc);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a clear.
        wr0 = wr_count;
        send(0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5000 && (wr_count - wr0) < 1000; i++) @(negedge clk);
        check("mid_clr_reached", 32'((wr_count - wr0) >= 1000), 32'd1);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        wr0 = wr_count;
        send(30, 30, 4, 1'b0, 1'b0);
        wait_idle(bc);
        check("post_rst_count", 32'(wr_count - wr0), 32'd9);
        check("post_rst_sb_empty", 32'(sb.size()), 32'd0);
        check("post_rst_last_x", 32'(last_x), 32'd31);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
